// File: rtl/kbd_mmio.sv
// kbd_mmio: PS/2 keyboard receiver with a scancode FIFO behind a small MMIO window.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   ps2_clk/data    raw asynchronous PS/2 lines
//   ce, we, addr    MMIO select, write strobe, byte offset (0x0 DATA, 0x4 STATUS)
//   data_i, data_o  MMIO write data / combinational read data
//   irq             high while the FIFO holds at least one byte
//   dbg_state_o     receiver FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Optional feature: define KBD_PARITY_CHECK_EN to reject frames whose data plus
// parity bit do not have an odd number of ones (sets sticky perr). Without it the
// parity bit is ignored and perr stays 0.
//
// MMIO handshake: an access is a single clk cycle with ce high; a DATA read pops on
// the rising edge that ends the cycle (only when non-empty), a STATUS write applies
// its clear bits on that same edge. There is no wait state and no ready signal.
module kbd_mmio #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 12500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq,
  output logic [1:0]  dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------- synchronizers and edge detect ----------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // ---------------- receiver FSM ----------------
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic           par_ok;
  logic           frame_push;
  logic           perr_set;

`ifdef KBD_PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_ok = ^{par_q, shift_q};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    frame_push = 1'b0;
    perr_set   = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
    par_d      = par_q;
`endif

    // Watchdog: only runs mid-frame, restarts on every falling edge.
    if (state_q == S_IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = S_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shift right and insert at the top.
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d    = S_IDLE;
          frame_push = dat_s2_q & par_ok;
          perr_set   = ~par_ok;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      to_cnt_q  <= '0;
`ifdef KBD_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
`ifdef KBD_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign dbg_state_o = state_q;

  // ---------------- FIFO and status ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, perr_q, perr_d;
  logic          empty, full, pop, push_ok, ovf_set, sw_wr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop     = ce & ~we & (addr == 4'h0) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = frame_push & (~full | pop);
  assign ovf_set = frame_push & full & ~pop;
  assign sw_wr   = ce & we & (addr == 4'h4);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Hardware set takes priority over a software clear in the same cycle.
    ovf_d  = ovf_set  | (ovf_q  & ~(sw_wr & data_i[1]));
    perr_d = perr_set | (perr_q & ~(sw_wr & data_i[2]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    data_o = 32'd0;
    case (addr)
      4'h0:    data_o = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
      4'h4:    data_o = {16'd0, 8'(count_q), 5'd0, perr_q, ovf_q, empty};
      default: data_o = 32'd0;
    endcase
  end

  assign irq = ~empty;

  logic unused_bits;
  assign unused_bits = ^{data_i[31:3], data_i[0]};

endmodule

// File: tb/tb_kbd_mmio.sv
// tb_kbd_mmio: self-checking bench for kbd_mmio. A vector table covers single
// frames; hand-written sequences cover overflow, timeout, push/pop collision and
// reset mid-frame. exp_q models the FIFO contents.
module tb_kbd_mmio;
  localparam int DEPTH = 8;
  localparam int TOUT  = 300;
  localparam int HALF  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        irq;
  logic [1:0]  dbg_state;

  kbd_mmio #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ce(ce), .we(we), .addr(addr), .data_i(data_i), .data_o(data_o),
    .irq(irq), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_perr = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [7:0] cnt;
    cnt = 8'(exp_q.size());
    return {16'd0, cnt, 5'd0, m_perr, m_ovf, (exp_q.size() == 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic mmio_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a;
    #1 d = data_o;
    @(negedge clk);
    ce = 1'b0; addr = 4'h0;
  endtask

  task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = 4'h0; data_i = 32'd0;
    if (a == 4'h4) begin
      if (d[1]) m_ovf = 1'b0;
      if (d[2]) m_perr = 1'b0;
    end
  endtask

  // One PS/2 bit. With pop=1 a DATA read is placed on the edge where the DUT
  // acts on this falling edge (2 synchronizer flops + 1 edge-detect flop).
  task automatic send_bit(input logic b, input logic pop, output logic [31:0] rd);
    rd = 32'd0;
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop) begin
      repeat (2) @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = 4'h0;
      #1 rd = data_o;
      @(negedge clk);
      ce = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic pop);
    logic [31:0] rd;
    logic        par;
    logic        valid;
    par = bad_par ? (^code) : ~(^code);
    send_bit(1'b0, 1'b0, rd);
    for (int i = 0; i < 8; i++) send_bit(code[i], 1'b0, rd);
    send_bit(par, 1'b0, rd);
    send_bit(1'b1, pop, rd);
    repeat (HALF) @(negedge clk);
    if (pop) begin
      if (exp_q.size() > 0) check("pop_at_push", rd, {24'd0, exp_q.pop_front()});
      else check("pop_at_push", rd, 32'd0);
    end
`ifdef KBD_PARITY_CHECK_EN
    valid = ~bad_par;
    if (bad_par) m_perr = 1'b1;
`else
    valid = 1'b1;
`endif
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(code);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic send_partial(input int nbits, input logic [7:0] code);
    logic [31:0] rd;
    send_bit(1'b0, 1'b0, rd);
    for (int i = 0; i < nbits; i++) send_bit(code[i], 1'b0, rd);
  endtask

  task automatic rd_data(input string name, output logic [31:0] d);
    mmio_read(4'h0, d);
    if (exp_q.size() > 0) check(name, d, {24'd0, exp_q.pop_front()});
    else check(name, d, 32'd0);
  endtask

  task automatic chk_status(input string name);
    logic [31:0] d;
    mmio_read(4'h4, d);
    check(name, d, m_status());
  endtask

  task automatic drain(input string name);
    logic [31:0] d;
    while (exp_q.size() > 0) rd_data(name, d);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] d;

    vecs[0] = '{8'h1C, 1'b0, 32'h0000_0100, 32'h0000_001C};
    vecs[1] = '{8'hFF, 1'b0, 32'h0000_0100, 32'h0000_00FF};
    vecs[2] = '{8'h00, 1'b0, 32'h0000_0100, 32'h0000_0000};
    vecs[3] = '{8'hA5, 1'b0, 32'h0000_0100, 32'h0000_00A5};
`ifdef KBD_PARITY_CHECK_EN
    vecs[4] = '{8'h1C, 1'b1, 32'h0000_0005, 32'h0000_0000};
`else
    vecs[4] = '{8'h1C, 1'b1, 32'h0000_0100, 32'h0000_001C};
`endif

    // Reset state
    do_reset();
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    mmio_read(4'h4, d);
    check("reset_status", d, 32'h0000_0001);
    mmio_read(4'h0, d);
    check("reset_data", d, 32'd0);
    mmio_read(4'h4, d);
    check("empty_read_no_pop", d, 32'h0000_0001);

    // Single frames from the table
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_par, 1'b0);
      check("vec_irq", {31'd0, irq}, {31'd0, (vecs[i].exp_status[15:8] != 8'd0)});
      mmio_read(4'h4, d);
      check("vec_status", d, vecs[i].exp_status);
      check("vec_status_model", d, m_status());
      rd_data("vec_data_model", d);
      check("vec_data", d, vecs[i].exp_data);
      mmio_write(4'h4, 32'h0000_0006);
      mmio_read(4'h4, d);
      check("vec_after", d, 32'h0000_0001);
    end

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    mmio_read(4'h4, d);
    check("ovf_status", d, 32'h0000_0802);
    drain("ovf_drain");
    chk_status("ovf_still_set");
    mmio_write(4'h4, 32'h0000_0002);
    mmio_read(4'h4, d);
    check("ovf_cleared", d, 32'h0000_0001);

    // Timeout mid-frame, then a full frame
    send_partial(4, 8'h77);
    check("mid_frame_state", {30'd0, dbg_state}, 32'd1);
    repeat (TOUT + 1) @(negedge clk);
    check("timeout_idle", {30'd0, dbg_state}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    mmio_read(4'h4, d);
    check("timeout_status", d, 32'h0000_0100);
    mmio_read(4'h8, d);
    check("reserved_read", d, 32'd0);
    mmio_read(4'h4, d);
    check("reserved_no_pop", d, 32'h0000_0100);
    drain("timeout_drain");

    // Full FIFO: frame completes on the same edge as a DATA pop
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    chk_status("full_status");
    send_frame(8'h99, 1'b0, 1'b1);
    mmio_read(4'h4, d);
    check("pushpop_full_status", d, 32'h0000_0800);
    drain("pushpop_drain");
    chk_status("pushpop_empty");

    // Push/pop collision with a single entry
    send_frame(8'h42, 1'b0, 1'b0);
    send_frame(8'h43, 1'b0, 1'b1);
    mmio_read(4'h4, d);
    check("pushpop_one_status", d, 32'h0000_0100);
    drain("pushpop_one_drain");

    // Reset mid-frame after the third data bit
    send_frame(8'h11, 1'b0, 1'b0);
    send_partial(3, 8'hC3);
    do_reset();
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h33, 1'b0, 1'b0);
    mmio_read(4'h4, d);
    check("rst_mid_status", d, 32'h0000_0100);
    rd_data("rst_mid_data_model", d);
    check("rst_mid_data", d, 32'h0000_0033);
    chk_status("final_status");
    check("final_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
